// File: rtl/postprocessing_pkg.sv
// Shared defaults and the per-sample fixed-point to RGB conversion used by
// the CeNN output post-processing block.
package postprocessing_pkg;

    localparam int DEF_WIDTH_FIXED  = 15;
    localparam int DEF_WIDTH_RGB    = 8;
    localparam int DEF_N_CH         = 2;
    localparam int DEF_LED_W        = 5;
    localparam int DEF_FRAME_PIXELS = 4096;
    localparam int DEF_INVERT       = 1;

    // Operands are sign-extended to 32 bits; the result sits in the low w_rgb bits.
    function automatic logic [31:0] fixed_to_rgb(
        input logic signed [31:0] sample,
        input logic signed [31:0] thr,
        input logic               gray,
        input logic               invert,
        input int                 w_fixed,
        input int                 w_rgb
    );
        logic [31:0] mask;
        logic [31:0] biased;
        logic [31:0] res;
        mask = (32'd1 << w_rgb) - 32'd1;
        if (gray) begin
            biased = sample + (32'sd1 <<< (w_fixed - 1));
            res    = (biased >> (w_fixed - w_rgb)) & mask;
        end else begin
            res = (sample >= thr) ? mask : 32'd0;
        end
        if (invert) begin
            res = res ^ mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/threshold_ctrl.sv
// Button edge detection and saturating threshold index; the index register
// doubles as the LED display value.
module threshold_ctrl
    import postprocessing_pkg::*;
#(
    parameter int LED_W = DEF_LED_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_press_up,
    input  logic             i_press_down,
    output logic [LED_W-1:0] o_thr_idx
);

    localparam logic [LED_W-1:0] IDX_MAX = '1;
    localparam logic [LED_W-1:0] IDX_MID = {1'b1, {(LED_W-1){1'b0}}};

    logic             r_up_d;
    logic             r_down_d;
    logic [LED_W-1:0] r_thr_idx;
    logic             w_up_edge;
    logic             w_down_edge;

    assign w_up_edge   = i_press_up & ~r_up_d;
    assign w_down_edge = i_press_down & ~r_down_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_up_d    <= 1'b0;
            r_down_d  <= 1'b0;
            r_thr_idx <= IDX_MID;
        end else begin
            r_up_d   <= i_press_up;
            r_down_d <= i_press_down;
            // Coincident edges cancel out.
            if (w_up_edge && !w_down_edge && r_thr_idx != IDX_MAX) begin
                r_thr_idx <= r_thr_idx + 1'b1;
            end else if (w_down_edge && !w_up_edge && r_thr_idx != '0) begin
                r_thr_idx <= r_thr_idx - 1'b1;
            end
        end
    end

    assign o_thr_idx = r_thr_idx;

endmodule

// File: rtl/postprocessing_multi.sv
// Two-stage multi-channel post-processing: CeNN fixed-point samples to
// binary or grayscale RGB, with frame-end marking and button threshold.
module postprocessing_multi
    import postprocessing_pkg::*;
#(
    parameter int WIDTH_FIXED  = DEF_WIDTH_FIXED,
    parameter int WIDTH_RGB    = DEF_WIDTH_RGB,
    parameter int N_CH         = DEF_N_CH,
    parameter int LED_W        = DEF_LED_W,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int INVERT       = DEF_INVERT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        press_up,
    input  logic                        press_down,
    input  logic                        mode_gray,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_CH*WIDTH_FIXED-1:0] in_pixel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_CH*WIDTH_RGB-1:0]   out_pixel,
    output logic                        out_last,
    output logic [LED_W-1:0]            led
);

    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic [LED_W-1:0]          w_thr_idx;
    logic signed [31:0]        w_thr;
    logic [N_CH*WIDTH_RGB-1:0] w_conv;
    logic                      w_advance;
    logic                      w_accept;
    logic                      w_last;

    logic                      r_s1_valid;
    logic [N_CH*WIDTH_RGB-1:0] r_s1_pixel;
    logic                      r_s1_last;
    logic                      r_out_valid;
    logic [N_CH*WIDTH_RGB-1:0] r_out_pixel;
    logic                      r_out_last;
    logic [CNT_W-1:0]          r_frame_cnt;

    threshold_ctrl #(.LED_W(LED_W)) u_threshold_ctrl (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_press_up   (press_up),
        .i_press_down (press_down),
        .o_thr_idx    (w_thr_idx)
    );

    // Threshold centred on zero: index midpoint maps to T = 0.
    assign w_thr = (signed'(32'(w_thr_idx)) - (32'sd1 <<< (LED_W - 1))) <<< (WIDTH_FIXED - LED_W);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [WIDTH_FIXED-1:0] w_sample;
        assign w_sample = in_pixel[k*WIDTH_FIXED +: WIDTH_FIXED];
        assign w_conv[k*WIDTH_RGB +: WIDTH_RGB] = WIDTH_RGB'(fixed_to_rgb(
            32'(w_sample), w_thr, mode_gray, INVERT != 0, WIDTH_FIXED, WIDTH_RGB));
    end

    // Whole pipeline moves in lockstep; a stalled output freezes both stages.
    assign w_advance = out_ready | ~r_out_valid;
    assign w_accept  = in_valid & w_advance;
    assign w_last    = (r_frame_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_pixel  <= '0;
            r_s1_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_frame_cnt <= w_last ? '0 : r_frame_cnt + 1'b1;
            end
            if (w_advance) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_pixel <= w_conv;
                    r_s1_last  <= w_last;
                end
                r_out_valid <= r_s1_valid;
                r_out_pixel <= r_s1_pixel;
                r_out_last  <= r_s1_valid & r_s1_last;
            end
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_last  = r_out_last;
    assign led       = w_thr_idx;

endmodule

// File: tb/tb_postprocessing_multi.sv
// Bench for postprocessing_multi: vector table, scoreboard queue and
// hand-written sequences for stalls, buttons, reset and frame marking.
module tb_postprocessing_multi;

    localparam int WF  = 15;
    localparam int WR  = 8;
    localparam int NCH = 2;
    localparam int LW  = 5;
    localparam int FP  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               press_up = 1'b0;
    logic               press_down = 1'b0;
    logic               mode_gray = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NCH*WF-1:0]  in_pixel = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [NCH*WR-1:0]  out_pixel;
    logic               out_last;
    logic [LW-1:0]      led;

    postprocessing_multi #(
        .WIDTH_FIXED  (WF),
        .WIDTH_RGB    (WR),
        .N_CH         (NCH),
        .LED_W        (LW),
        .FRAME_PIXELS (FP),
        .INVERT       (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .press_up   (press_up),
        .press_down (press_down),
        .mode_gray  (mode_gray),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_last   (out_last),
        .led        (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          gray;
        int          s0;
        int          s1;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t        tbl[6];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] exp_q[$];
    int          tb_frame = 0;
    int          out_num = 0;
    int          thr_model = 16;
    bit          last_at[0:31];
    logic [15:0] drv_exp = '0;
    bit          acc = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_pix = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one channel with INVERT=1.
    function automatic logic [7:0] ref_ch(input int s, input int thr, input bit gray);
        int v;
        if (gray) v = (s + 16384) / 128;
        else      v = (s >= (thr - 16) * 1024) ? 255 : 0;
        return 8'(255 - v);
    endfunction

    function automatic logic [15:0] ref_pix(input int s0, input int s1, input int thr, input bit gray);
        return {ref_ch(s1, thr, gray), ref_ch(s0, thr, gray)};
    endfunction

    // One clock: sample settled signals, run scoreboard, advance to next negedge.
    task automatic cyc();
        logic [16:0] e;
        #1;
        acc = 0;
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pixel", out_pixel, prev_pix);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_pixel);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pixel", out_pixel, e[15:0]);
                    chk("out_last", out_last, e[16]);
                    if (out_num < 32) last_at[out_num] = out_last;
                    out_num++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({tb_frame == FP - 1, drv_exp});
                tb_frame = (tb_frame == FP - 1) ? 0 : tb_frame + 1;
                acc = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pixel;
            prev_last  = out_last;
        end else begin
            prev_stall = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 50) begin
            cyc();
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic press(input logic up, input logic down);
        press_up   = up;
        press_down = down;
        cyc();
        press_up   = 1'b0;
        press_down = 1'b0;
        cyc();
    endtask

    task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit toggle);
        int sent = 0;
        int c = 0;
        int s0, s1;
        bit g = 0;
        s0 = int'($urandom_range(0, 32767)) - 16384;
        s1 = int'($urandom_range(0, 32767)) - 16384;
        while (sent < n && c < 500) begin
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            in_valid  = 1'b1;
            in_pixel  = {15'(s1), 15'(s0)};
            mode_gray = g;
            drv_exp   = ref_pix(s0, s1, thr_model, g);
            cyc();
            c++;
            if (acc) begin
                sent++;
                s0 = int'($urandom_range(0, 32767)) - 16384;
                s1 = int'($urandom_range(0, 32767)) - 16384;
                if (toggle) g = ~g;
            end
        end
        chk("stream_sent", sent, n);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        tbl[0] = '{0, 0, -1, 8'h00, 8'hFF};
        tbl[1] = '{0, 16383, -16384, 8'h00, 8'hFF};
        tbl[2] = '{0, 1, -1, 8'h00, 8'hFF};
        tbl[3] = '{1, -16384, 0, 8'hFF, 8'h7F};
        tbl[4] = '{1, 16383, 127, 8'h00, 8'h7F};
        tbl[5] = '{1, 16383, -129, 8'h00, 8'h81};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_led", led, 16);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Vector table at T = 0
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            mode_gray = tbl[i].gray;
            in_pixel  = {15'(tbl[i].s1), 15'(tbl[i].s0)};
            drv_exp   = {tbl[i].e1, tbl[i].e0};
            cyc();
            chk("tbl_accept", acc, 1);
        end
        drain();

        // Single-transfer latency
        in_valid  = 1'b1;
        mode_gray = 1'b0;
        in_pixel  = {15'(-5), 15'(5)};
        drv_exp   = ref_pix(5, -5, thr_model, 0);
        cyc();
        in_valid  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("latency", lat, 2);
        drain();

        // Buttons: 20 up pulses saturate at 31
        for (int i = 0; i < 20; i++) begin
            press(1'b1, 1'b0);
            thr_model = (17 + i > 31) ? 31 : 17 + i;
            chk("led_up", led, thr_model);
        end
        press(1'b1, 1'b1);
        chk("led_both_sat", led, 31);
        press(1'b0, 1'b1);
        chk("led_down", led, 30);
        press(1'b1, 1'b1);
        chk("led_both", led, 30);
        press_up = 1'b1;
        repeat (3) cyc();
        press_up = 1'b0;
        cyc();
        chk("led_held", led, 31);
        press(1'b0, 1'b1);
        thr_model = 30;
        chk("led_down2", led, 30);

        // Threshold boundary and sampling at acceptance (T = 14336)
        in_valid  = 1'b1;
        mode_gray = 1'b0;
        in_pixel  = {15'(14335), 15'(14336)};
        drv_exp   = 16'hFF00;
        cyc();
        in_pixel  = {15'(15360), 15'(14336)};
        drv_exp   = 16'h0000;
        press_up  = 1'b1;
        cyc();
        press_up  = 1'b0;
        drv_exp   = 16'h00FF;
        cyc();
        thr_model = 31;
        drain();
        chk("led_thr31", led, 31);

        // Stream of 10 with a 5-cycle output stall, mode toggling per transfer
        out_num = 0;
        run_stream(10, 4, 5, 1);
        chk("stall_count", out_num, 10);

        // Reset mid-stream
        in_valid  = 1'b1;
        mode_gray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pixel = {15'(i * 100), 15'(-i * 100)};
            drv_exp  = ref_pix(-i * 100, i * 100, thr_model, 1);
            cyc();
        end
        rst = 1'b1;
        cyc();
        chk("midrst_out_valid", out_valid, 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        exp_q.delete();
        tb_frame  = 0;
        thr_model = 16;
        out_num   = 0;
        chk("midrst_led", led, 16);

        // Frame marking, FRAME_PIXELS = 4
        for (int i = 0; i < 32; i++) last_at[i] = 0;
        run_stream(9, 1000, 0, 0);
        for (int i = 0; i < 9; i++) begin
            chk("frame_last", last_at[i], (i == 3 || i == 7) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
